tugemm_job_sched: RTL and testbench

// Round-robin scheduler that shares one tuGEMM_8x8 temporal-unary GEMM core among NUM_REQ requesters.
// It accepts an 8x8 x 8x8 job (two 512-bit packed int8 matrices) through a valid/ready handshake.
// It clears the core, holds the operands stable while the core runs, and waits for core_done or a timeout.
// It then returns the captured 8x8 result, tagged with the requester id, on a valid/ready response port.

---
 rtl/tugemm_job_sched.sv | 116 +++++++++++
 tb/tb_tugemm_job_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tugemm_job_sched.sv
// tugemm_job_sched: round-robin scheduler sharing one tuGEMM 8x8 core among NUM_REQ requesters.
// Jobs are cleared into the core, run until done or timeout, and returned tagged with the owner id.
module tugemm_job_sched #(
  parameter int NUM_REQ = 2,
  parameter int RES_W   = 19,
  parameter int TMO_CYC = 262143,
  parameter int TMO_W   = 18
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*512-1:0]     req_a,
  input  logic [NUM_REQ*512-1:0]     req_b,
  output logic                       core_clr,
  output logic [511:0]               core_a,
  output logic [511:0]               core_b,
  input  logic                       core_done,
  input  logic [64*RES_W-1:0]        core_res,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [64*RES_W-1:0]        rsp_data,
  output logic                       rsp_tmo,
  output logic                       busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_RESP} state_t;
  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [TMO_W-1:0]    r_cnt;
  logic                r_clr;
  logic                r_rsp_valid;
  logic                r_rsp_tmo;
  logic [511:0]        r_a;
  logic [511:0]        r_b;
  logic [64*RES_W-1:0] r_data;
  logic [ID_W-1:0]     w_gnt;
  logic                w_gnt_vld;
  logic                w_hs;
  // lowest offset from r_ptr wins, so scan offsets from high to low
  always_comb begin
    w_gnt = '0;
    w_gnt_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [ID_W:0] idx;
      idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      idx = (idx >= (ID_W+1)'(NUM_REQ)) ? idx - (ID_W+1)'(NUM_REQ) : idx;
      if (req_valid[idx[ID_W-1:0]]) begin
        w_gnt = idx[ID_W-1:0];
        w_gnt_vld = 1'b1;
      end
    end
  end
  assign w_hs      = (r_state == S_IDLE) & w_gnt_vld & rst;
  assign req_ready = w_hs ? NUM_REQ'(1) << w_gnt : '0;
  assign core_clr  = r_clr;
  assign core_a    = r_a;
  assign core_b    = r_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_tmo   = r_rsp_tmo;
  assign busy      = r_state != S_IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_clr       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_data      <= '0;
    end else begin
      r_clr <= 1'b0;
      case (r_state)
        S_IDLE: if (w_hs) begin
          r_a     <= req_a[w_gnt*512 +: 512];
          r_b     <= req_b[w_gnt*512 +: 512];
          r_id    <= w_gnt;
          r_ptr   <= (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
          r_clr   <= 1'b1;
          r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (core_done) begin
            r_data      <= core_res;
            r_rsp_tmo   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_cnt == TMO_W'(TMO_CYC - 1)) begin
            r_data      <= '0;
            r_rsp_tmo   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tugemm_job_sched.sv
// tb_tugemm_job_sched: random and directed stimulus against a job-level reference model of the scheduler.
// The model tracks the current job by age since acceptance and checks every DUT output each cycle.
module tb_tugemm_job_sched;
  localparam int N   = 3;
  localparam int RW  = 19;
  localparam int TMO = 100;
  localparam int IW  = $clog2(N);
  localparam int DW  = 64 * RW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*512-1:0] req_a = '0;
  logic [N*512-1:0] req_b = '0;
  logic            core_clr;
  logic [511:0]    core_a;
  logic [511:0]    core_b;
  logic            core_done = 1'b0;
  logic [DW-1:0]   core_res;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_tmo;
  logic            busy;

  tugemm_job_sched #(.NUM_REQ(N), .RES_W(RW), .TMO_CYC(TMO), .TMO_W(7)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .core_clr(core_clr), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_res(core_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_tmo(rsp_tmo), .busy(busy)
  );

  always #5 clk = ~clk;

  // true signed int8 8x8 matrix product, element i*8+j
  function automatic logic [DW-1:0] mm(input logic [511:0] a, input logic [511:0] b);
    logic [DW-1:0] r;
    logic signed [RW-1:0] s;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        s = '0;
        for (int t = 0; t < 8; t++)
          s = s + RW'($signed(a[8*(8*i+t) +: 8]) * $signed(b[8*(8*t+j) +: 8]));
        r[RW*(8*i+j) +: RW] = s;
      end
    return r;
  endfunction

  assign core_res = mm(core_a, core_b);

  int n_vec = 0, n_err = 0, cyc = 0;
  int core_mode = 1, core_p = 0, core_lat = 0, cc = 0;
  logic [N-1:0] gen_mask = '0;
  int p_req = 0, p_rdy = 100;
  bit rnd_rdy = 0;

  bit m_act, m_resp, m_tmo;
  int m_age, m_ptr, m_id;
  logic [511:0] m_a, m_b;
  logic [DW-1:0] m_data, m_exp;

  logic [N-1:0] acc;
  int t_clr = -1, t_rsp = -1, t_hs = -1, t_acc = -1, clr_cnt = 0;
  bit seen_rv = 0, prev_rv = 0;
  int ids[$];

  // core stand-in: done is random, never, or a fixed number of cycles after the clear pulse
  initial forever begin
    @(posedge clk); #1;
    cc = core_clr ? 0 : cc + 1;
    core_done = core_mode == 0 ? ($urandom_range(0, 99) < core_p) :
                core_mode == 2 ? (cc == core_lat) : 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int b;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      b = 0;
      for (int i = DW - 1; i >= 0; i--) if (act[i] !== exp[i]) b = i;
      if (b > DW - 32) b = DW - 32;
      $display("FAIL %s: bits from %0d got %h expected %h (cycle %0d)", nm, b, act[b +: 32], exp[b +: 32], cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  task automatic model_reset();
    m_act = 0; m_resp = 0; m_tmo = 0; m_age = 0; m_ptr = 0; m_id = 0;
    m_a = '0; m_b = '0; m_data = '0; m_exp = '0;
  endtask

  task automatic check();
    int g;
    logic [N-1:0] er;
    cyc++;
    if (!rst) model_reset();
    g = -1;
    for (int k = N - 1; k >= 0; k--) if (req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    er = (!m_act && rst && g >= 0) ? N'(1) << g : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("busy", 64'(busy), 64'(m_act));
    chk("core_clr", 64'(core_clr), 64'(m_act && !m_resp && m_age == 1));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_resp));
    chk("rsp_id", 64'(rsp_id), 64'(m_id));
    chk("rsp_tmo", 64'(rsp_tmo), 64'(m_tmo));
    chkw("rsp_data", rsp_data, m_data);
    chkw("core_a", DW'(core_a), DW'(m_a));
    chkw("core_b", DW'(core_b), DW'(m_b));
    acc = er;
    if (core_clr) begin clr_cnt++; t_clr = cyc; end
    if (rsp_valid && !prev_rv) begin t_rsp = cyc; seen_rv = 1; end
    prev_rv = rsp_valid;
    if (rsp_valid && rsp_ready) begin ids.push_back(int'(rsp_id)); t_hs = cyc; end
    if ((req_ready & req_valid) != 0) t_acc = cyc;
    if (rst) begin
      if (!m_act) begin
        if (g >= 0) begin
          m_act = 1; m_age = 1; m_id = g; m_ptr = (g + 1) % N;
          m_a = req_a[g*512 +: 512]; m_b = req_b[g*512 +: 512];
          m_exp = mm(m_a, m_b);
        end
      end else if (m_resp) begin
        if (rsp_ready) begin m_act = 0; m_resp = 0; end
      end else if (m_age == 1) m_age = 2;
      else if (core_done) begin m_resp = 1; m_data = m_exp; m_tmo = 0; end
      else if (m_age - 2 == TMO - 1) begin m_resp = 1; m_data = '0; m_tmo = 1; end
      else m_age++;
    end
  endtask

  task automatic rand_slice(input int i);
    for (int w = 0; w < 16; w++) begin
      req_a[i*512 + w*32 +: 32] = $urandom();
      req_b[i*512 + w*32 +: 32] = $urandom();
    end
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && gen_mask[i] && $urandom_range(0, 99) < p_req) begin
        req_valid[i] = 1'b1;
        rand_slice(i);
      end
    end
    if (rnd_rdy) rsp_ready = $urandom_range(0, 99) < p_rdy;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) step();
    rst = 1'b1;
  endtask

  task automatic wait_rv(input int lim);
    int n = 0;
    seen_rv = 0;
    while (!seen_rv && n < lim) begin step(); n++; end
    if (!seen_rv) bound_fail("wait_rsp_valid");
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while ((busy || req_valid != 0) && n < lim) begin step(); n++; end
    if (busy || req_valid != 0) bound_fail("drain");
  endtask

  initial begin
    logic [DW-1:0] twos;
    int n;
    model_reset();
    // reset and idle
    do_reset(4);
    repeat (5) step();
    chk("t1_busy_idle", 64'(busy), 64'd0);
    // single job: identity x all-2 gives all-2
    for (int i = 0; i < 8; i++) req_a[8*(9*i) +: 8] = 8'd1;
    req_b[511:0] = {64{8'd2}};
    req_valid[0] = 1'b1;
    rsp_ready = 1'b1;
    core_mode = 2; core_lat = 5; clr_cnt = 0;
    wait_rv(50);
    for (int k = 0; k < 64; k++) twos[k*RW +: RW] = 19'd2;
    chk("t2_id", 64'(rsp_id), 64'd0);
    chk("t2_tmo", 64'(rsp_tmo), 64'd0);
    chkw("t2_data", rsp_data, twos);
    chk("t2_clr_pulses", 64'(clr_cnt), 64'd1);
    drain(50);
    // round-robin with two always-valid requesters
    do_reset(2);
    ids.delete();
    gen_mask = 3'b011; p_req = 100; core_mode = 0; core_p = 30;
    n = 0;
    while (ids.size() < 4 && n < 2000) begin step(); n++; end
    gen_mask = '0;
    chk("t3_count", 64'(ids.size()), 64'd4);
    for (int k = 0; k < 4 && k < ids.size(); k++) chk($sformatf("t3_id%0d", k), 64'(ids[k]), 64'(k % 2));
    drain(2000);
    // back-pressure on the response port
    rsp_ready = 1'b0; core_mode = 2; core_lat = 3;
    rand_slice(0); req_valid[0] = 1'b1;
    wait_rv(50);
    rand_slice(2); req_valid[2] = 1'b1;
    t_acc = -1; t_hs = -1;
    repeat (10) step();
    chk("t4_held_valid", 64'(rsp_valid), 64'd1);
    chk("t4_no_grant", 64'(t_acc), 64'(-1));
    rsp_ready = 1'b1;
    n = 0;
    while (t_acc < 0 && n < 20) begin step(); n++; end
    chk("t4_grant_gap", 64'(t_acc - t_hs), 64'd1);
    drain(100);
    // timeout, then done coinciding with timeout
    core_mode = 1; rand_slice(1); req_valid[1] = 1'b1; t_clr = -1;
    wait_rv(300);
    chk("t5_tmo_lat", 64'(t_rsp - t_clr), 64'd101);
    chk("t5_tmo_flag", 64'(rsp_tmo), 64'd1);
    chkw("t5_tmo_data", rsp_data, '0);
    drain(50);
    core_mode = 2; core_lat = 100; rand_slice(0); req_valid[0] = 1'b1; t_clr = -1;
    wait_rv(300);
    chk("t5_tie_tmo", 64'(rsp_tmo), 64'd0);
    chk("t5_tie_lat", 64'(t_rsp - t_clr), 64'd101);
    drain(50);
    // reset in the middle of RUN
    do_reset(2);
    core_mode = 1; rand_slice(0); req_valid[0] = 1'b1; t_clr = -1;
    n = 0;
    while (t_clr < 0 && n < 20) begin step(); n++; end
    rand_slice(1); req_valid[1] = 1'b1;
    repeat (50) step();
    rst = 1'b0;
    step();
    chk("t6_busy_rst", 64'(busy), 64'd0);
    chk("t6_rv_rst", 64'(rsp_valid), 64'd0);
    step();
    rst = 1'b1;
    clr_cnt = 0; core_mode = 2; core_lat = 3;
    wait_rv(50);
    chk("t6_id", 64'(rsp_id), 64'd1);
    chk("t6_clr", 64'(clr_cnt), 64'd1);
    drain(50);
    // random traffic with random back-pressure and occasional timeouts
    rnd_rdy = 1; p_rdy = 60; gen_mask = '1; p_req = 40; core_mode = 0; core_p = 3;
    repeat (4000) step();
    gen_mask = '0; rnd_rdy = 0; rsp_ready = 1'b1;
    drain(2000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
